// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the 1-to-3 AXI4-lite address router.
// Holds the read/write FSM state encodings, the decoded target encoding,
// the AXI response codes and a helper that turns a target into a slave one-hot.
package axi_xbar_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ERR} wstate_e;

  typedef enum logic [1:0] {
    S_SRAM  = 2'd0,
    S_UART  = 2'd1,
    S_CLINT = 2'd2,
    S_ERR   = 2'd3
  } target_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Per-slave select; the error target selects no slave at all.
  function automatic logic [2:0] tgt_onehot(target_e t);
    return (t == S_ERR) ? 3'b000 : (3'b001 << t);
  endfunction

endpackage

// File: rtl/axi_xbar_if.sv
// Bus bundle between the memory-bus arbiter (in_*) and the three SoC slaves (s_*).
// Per-slave vectors are packed {s2,s1,s0}; s_araddr/s_awaddr/s_wdata/s_wstrb are broadcast.
// Modports:
//   slave  - the crossbar's view (AXI slave towards the arbiter)
//   master - the surrounding environment's view (arbiter plus slaves)
interface axi_xbar_if;
  logic        in_arvalid, in_rready;
  logic [31:0] in_araddr;
  logic        in_arready, in_rvalid, in_rlast;
  logic [1:0]  in_rresp;
  logic [31:0] in_rdata;
  logic        in_awvalid, in_wvalid, in_bready;
  logic [31:0] in_awaddr, in_wdata;
  logic [3:0]  in_wstrb;
  logic        in_awready, in_wready, in_bvalid;
  logic [1:0]  in_bresp;
  logic [2:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
  logic [5:0]  s_rresp, s_bresp;
  logic [95:0] s_rdata;

  modport slave (
    input  in_arvalid, in_rready, in_araddr, in_awvalid, in_wvalid, in_bready,
           in_awaddr, in_wdata, in_wstrb,
           s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid,
           s_rresp, s_bresp, s_rdata,
    output in_arready, in_rvalid, in_rlast, in_rresp, in_rdata,
           in_awready, in_wready, in_bvalid, in_bresp,
           s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
           s_araddr, s_awaddr, s_wdata, s_wstrb
  );

  modport master (
    output in_arvalid, in_rready, in_araddr, in_awvalid, in_wvalid, in_bready,
           in_awaddr, in_wdata, in_wstrb,
           s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid,
           s_rresp, s_bresp, s_rdata,
    input  in_arready, in_rvalid, in_rlast, in_rresp, in_rdata,
           in_awready, in_wready, in_bvalid, in_bresp,
           s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
           s_araddr, s_awaddr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/axi_addr_decode.sv
// Combinational address decoder: maps a 32-bit address onto a slave target.
// Ports: i_addr (address), o_target (S_SRAM/S_UART/S_CLINT, or S_ERR when unmapped).
module axi_addr_decode
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE  = 32'h0800_0000,
  parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0008,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0010
) (
  input  logic [31:0] i_addr,
  output target_e     o_target
);

  // 33-bit compare so a region ending at 2^32 does not wrap to zero.
  function automatic logic hit(logic [31:0] a, logic [31:0] base, logic [31:0] size);
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
  endfunction

  always_comb begin
    o_target = S_ERR;
    if (hit(i_addr, SRAM_BASE, SRAM_SIZE))        o_target = S_SRAM;
    else if (hit(i_addr, UART_BASE, UART_SIZE))   o_target = S_UART;
    else if (hit(i_addr, CLINT_BASE, CLINT_SIZE)) o_target = S_CLINT;
  end

endmodule

// File: rtl/axi_xbar.sv
// 1-to-3 AXI4-lite router: SRAM (slave0), UART (slave1), CLINT (slave2).
// Independent read and write FSMs, one outstanding transaction each; unmapped
// addresses are answered locally with DECERR. All outputs are combinational
// from state, latched target and inputs.
// Ports: clk, rst (async, active-low), bus (axi_xbar_if.slave: upstream in_* and per-slave s_*).
module axi_xbar
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE  = 32'h0800_0000,
  parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0008,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0010
) (
  input  logic      clk,
  input  logic      rst,
  axi_xbar_if.slave bus
);

  target_e    w_ar_tgt, w_aw_tgt;
  rstate_e    r_rstate, w_rstate_d;
  wstate_e    r_wstate, w_wstate_d;
  target_e    r_rtarget, w_rtarget_d, r_wtarget, w_wtarget_d;
  logic       r_rerr_acked, w_rerr_acked_d;
  logic       r_aw_done, w_aw_done_d, r_w_done, w_w_done_d;
  logic [2:0] w_rsel, w_wsel;
  logic       w_ar_rdy, w_aw_rdy, w_w_rdy;

  axi_addr_decode #(
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE), .UART_BASE(UART_BASE),
    .UART_SIZE(UART_SIZE), .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)
  ) u_ar_dec (
    .i_addr  (bus.in_araddr),
    .o_target(w_ar_tgt)
  );

  axi_addr_decode #(
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE), .UART_BASE(UART_BASE),
    .UART_SIZE(UART_SIZE), .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)
  ) u_aw_dec (
    .i_addr  (bus.in_awaddr),
    .o_target(w_aw_tgt)
  );

  assign w_rsel = tgt_onehot(r_rtarget);
  assign w_wsel = tgt_onehot(r_wtarget);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate     <= R_IDLE;
      r_rtarget    <= S_SRAM;
      r_rerr_acked <= 1'b0;
      r_wstate     <= W_IDLE;
      r_wtarget    <= S_SRAM;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      r_rstate     <= w_rstate_d;
      r_rtarget    <= w_rtarget_d;
      r_rerr_acked <= w_rerr_acked_d;
      r_wstate     <= w_wstate_d;
      r_wtarget    <= w_wtarget_d;
      r_aw_done    <= w_aw_done_d;
      r_w_done     <= w_w_done_d;
    end
  end

  // Read channel.
  always_comb begin
    w_rstate_d     = r_rstate;
    w_rtarget_d    = r_rtarget;
    w_rerr_acked_d = r_rerr_acked;
    w_ar_rdy       = |(bus.s_arready & w_rsel);
    bus.in_arready = 1'b0;
    bus.in_rvalid  = 1'b0;
    bus.in_rlast   = 1'b0;
    bus.in_rresp   = RESP_OKAY;
    bus.in_rdata   = '0;
    bus.s_arvalid  = '0;
    bus.s_rready   = '0;
    bus.s_araddr   = '0;
    unique case (r_rstate)
      R_IDLE: begin
        if (bus.in_arvalid) begin
          w_rtarget_d    = w_ar_tgt;
          w_rerr_acked_d = 1'b0;
          w_rstate_d     = (w_ar_tgt == S_ERR) ? R_ERR : R_ADDR;
        end
      end
      R_ADDR: begin
        bus.s_arvalid  = w_rsel & {3{bus.in_arvalid}};
        bus.s_araddr   = bus.in_araddr;
        bus.in_arready = w_ar_rdy;
        if (bus.in_arvalid && w_ar_rdy) w_rstate_d = R_DATA;
      end
      R_DATA: begin
        bus.in_rvalid = |(bus.s_rvalid & w_rsel);
        bus.in_rlast  = |(bus.s_rlast & w_rsel);
        bus.s_rready  = w_rsel & {3{bus.in_rready}};
        case (r_rtarget)
          S_SRAM:  begin bus.in_rdata = bus.s_rdata[31:0];  bus.in_rresp = bus.s_rresp[1:0]; end
          S_UART:  begin bus.in_rdata = bus.s_rdata[63:32]; bus.in_rresp = bus.s_rresp[3:2]; end
          S_CLINT: begin bus.in_rdata = bus.s_rdata[95:64]; bus.in_rresp = bus.s_rresp[5:4]; end
          default: ;
        endcase
        if (bus.in_rvalid && bus.in_rready && bus.in_rlast) w_rstate_d = R_IDLE;
      end
      R_ERR: begin
        // First cycle swallows the AR beat, then a single-beat DECERR response.
        if (!r_rerr_acked) begin
          bus.in_arready = 1'b1;
          w_rerr_acked_d = 1'b1;
        end else begin
          bus.in_rvalid = 1'b1;
          bus.in_rresp  = RESP_DECERR;
          bus.in_rlast  = 1'b1;
          if (bus.in_rready) w_rstate_d = R_IDLE;
        end
      end
      default: w_rstate_d = R_IDLE;
    endcase
  end

  // Write channel. AW and W complete independently; a done channel is masked.
  always_comb begin
    w_wstate_d     = r_wstate;
    w_wtarget_d    = r_wtarget;
    w_aw_done_d    = r_aw_done;
    w_w_done_d     = r_w_done;
    w_aw_rdy       = ~r_aw_done & |(bus.s_awready & w_wsel);
    w_w_rdy        = ~r_w_done & |(bus.s_wready & w_wsel);
    bus.in_awready = 1'b0;
    bus.in_wready  = 1'b0;
    bus.in_bvalid  = 1'b0;
    bus.in_bresp   = RESP_OKAY;
    bus.s_awvalid  = '0;
    bus.s_wvalid   = '0;
    bus.s_bready   = '0;
    bus.s_awaddr   = '0;
    bus.s_wdata    = '0;
    bus.s_wstrb    = '0;
    unique case (r_wstate)
      W_IDLE: begin
        if (bus.in_awvalid && bus.in_wvalid) begin
          w_wtarget_d = w_aw_tgt;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
          w_wstate_d  = (w_aw_tgt == S_ERR) ? W_ERR : W_REQ;
        end
      end
      W_REQ: begin
        bus.s_awvalid  = w_wsel & {3{bus.in_awvalid & ~r_aw_done}};
        bus.s_wvalid   = w_wsel & {3{bus.in_wvalid & ~r_w_done}};
        bus.s_awaddr   = bus.in_awaddr;
        bus.s_wdata    = bus.in_wdata;
        bus.s_wstrb    = bus.in_wstrb;
        bus.in_awready = w_aw_rdy;
        bus.in_wready  = w_w_rdy;
        w_aw_done_d    = r_aw_done | (bus.in_awvalid & w_aw_rdy);
        w_w_done_d     = r_w_done | (bus.in_wvalid & w_w_rdy);
        if (w_aw_done_d && w_w_done_d) w_wstate_d = W_RESP;
      end
      W_RESP: begin
        bus.in_bvalid = |(bus.s_bvalid & w_wsel);
        bus.s_bready  = w_wsel & {3{bus.in_bready}};
        case (r_wtarget)
          S_SRAM:  bus.in_bresp = bus.s_bresp[1:0];
          S_UART:  bus.in_bresp = bus.s_bresp[3:2];
          S_CLINT: bus.in_bresp = bus.s_bresp[5:4];
          default: ;
        endcase
        if (bus.in_bvalid && bus.in_bready) w_wstate_d = W_IDLE;
      end
      W_ERR: begin
        // Flags were cleared on entry; reuse them to mark the accept cycle.
        if (!r_aw_done) begin
          bus.in_awready = 1'b1;
          bus.in_wready  = 1'b1;
          w_aw_done_d    = 1'b1;
          w_w_done_d     = 1'b1;
        end else begin
          bus.in_bvalid = 1'b1;
          bus.in_bresp  = RESP_DECERR;
          if (bus.in_bready) w_wstate_d = W_IDLE;
        end
      end
      default: w_wstate_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_xbar.sv
module tb_axi_xbar;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_xbar_if bus();
  axi_xbar u_dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0] beats [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Address map as plain range arithmetic; -1 means unmapped.
  function automatic int decode(input logic [31:0] a);
    longint unsigned x;
    x = {32'h0, a};
    if (x >= 64'h8000_0000 && x < 64'h8000_0000 + 64'h0800_0000) return 0;
    if (x >= 64'ha000_03f8 && x < 64'ha000_03f8 + 64'h8) return 1;
    if (x >= 64'ha000_0048 && x < 64'ha000_0048 + 64'h10) return 2;
    return -1;
  endfunction

  // Transaction-level model: one open read and one open write at a time.
  bit rd_act = 0, rd_taken = 0, rd_ack = 0;
  int rd_tgt = 0;
  bit wr_act = 0, aw_t = 0, w_t = 0, wr_ack = 0;
  int wr_tgt = 0;

  always @(negedge clk) begin : cmp
    logic [2:0] e_arv, e_rrdy, e_awv, e_wv, e_brdy;
    logic e_arr, e_rv, e_rl, e_awr, e_wr, e_bv;
    logic [1:0] e_rresp, e_bresp;
    logic [31:0] e_rdata, e_araddr, e_awaddr, e_wdata;
    logic [3:0] e_wstrb;
    e_arv = 0; e_rrdy = 0; e_awv = 0; e_wv = 0; e_brdy = 0;
    e_arr = 0; e_rv = 0; e_rl = 0; e_awr = 0; e_wr = 0; e_bv = 0;
    e_rresp = 0; e_bresp = 0; e_rdata = 0; e_araddr = 0; e_awaddr = 0; e_wdata = 0;
    e_wstrb = 0;

    if (rst && rd_act) begin
      if (rd_tgt < 0) begin
        if (!rd_ack) e_arr = 1;
        else begin e_rv = 1; e_rresp = 2'b11; e_rl = 1; end
      end else if (!rd_taken) begin
        e_arv    = bus.in_arvalid ? (3'b001 << rd_tgt) : 3'b000;
        e_araddr = bus.in_araddr;
        e_arr    = bus.s_arready[rd_tgt];
      end else begin
        e_rv    = bus.s_rvalid[rd_tgt];
        e_rl    = bus.s_rlast[rd_tgt];
        e_rresp = bus.s_rresp[2*rd_tgt +: 2];
        e_rdata = bus.s_rdata[32*rd_tgt +: 32];
        e_rrdy  = bus.in_rready ? (3'b001 << rd_tgt) : 3'b000;
      end
    end
    if (rst && wr_act) begin
      if (wr_tgt < 0) begin
        if (!wr_ack) begin e_awr = 1; e_wr = 1; end
        else begin e_bv = 1; e_bresp = 2'b11; end
      end else if (!(aw_t && w_t)) begin
        e_awv    = (bus.in_awvalid && !aw_t) ? (3'b001 << wr_tgt) : 3'b000;
        e_wv     = (bus.in_wvalid && !w_t) ? (3'b001 << wr_tgt) : 3'b000;
        e_awr    = !aw_t && bus.s_awready[wr_tgt];
        e_wr     = !w_t && bus.s_wready[wr_tgt];
        e_awaddr = bus.in_awaddr;
        e_wdata  = bus.in_wdata;
        e_wstrb  = bus.in_wstrb;
      end else begin
        e_bv    = bus.s_bvalid[wr_tgt];
        e_bresp = bus.s_bresp[2*wr_tgt +: 2];
        e_brdy  = bus.in_bready ? (3'b001 << wr_tgt) : 3'b000;
      end
    end

    check("rd_up", 128'({bus.in_arready, bus.in_rvalid, bus.in_rlast, bus.in_rresp, bus.in_rdata}),
          128'({e_arr, e_rv, e_rl, e_rresp, e_rdata}));
    check("rd_slv", 128'({bus.s_arvalid, bus.s_rready, bus.s_araddr}),
          128'({e_arv, e_rrdy, e_araddr}));
    check("wr_up", 128'({bus.in_awready, bus.in_wready, bus.in_bvalid, bus.in_bresp}),
          128'({e_awr, e_wr, e_bv, e_bresp}));
    check("wr_slv", 128'({bus.s_awvalid, bus.s_wvalid, bus.s_bready, bus.s_awaddr, bus.s_wdata,
                          bus.s_wstrb}),
          128'({e_awv, e_wv, e_brdy, e_awaddr, e_wdata, e_wstrb}));

    // Advance the model to the state after the coming rising edge.
    if (!rst) begin
      rd_act = 0;
      wr_act = 0;
    end else begin
      if (!rd_act) begin
        if (bus.in_arvalid) begin
          rd_act = 1; rd_tgt = decode(bus.in_araddr); rd_taken = 0; rd_ack = 0;
        end
      end else if (rd_tgt < 0) begin
        if (!rd_ack) rd_ack = 1;
        else if (bus.in_rready) rd_act = 0;
      end else if (!rd_taken) begin
        if (bus.in_arvalid && e_arr) rd_taken = 1;
      end else if (e_rv && bus.in_rready && e_rl) begin
        rd_act = 0;
      end

      if (!wr_act) begin
        if (bus.in_awvalid && bus.in_wvalid) begin
          wr_act = 1; wr_tgt = decode(bus.in_awaddr); aw_t = 0; w_t = 0; wr_ack = 0;
        end
      end else if (wr_tgt < 0) begin
        if (!wr_ack) wr_ack = 1;
        else if (bus.in_bready) wr_act = 0;
      end else if (!(aw_t && w_t)) begin
        if (bus.in_awvalid && e_awr) aw_t = 1;
        if (bus.in_wvalid && e_wr) w_t = 1;
      end else if (e_bv && bus.in_bready) begin
        wr_act = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_arvalid = 0; bus.in_rready = 0; bus.in_araddr = 0;
    bus.in_awvalid = 0; bus.in_wvalid = 0; bus.in_bready = 0;
    bus.in_awaddr = 0; bus.in_wdata = 0; bus.in_wstrb = 0;
    bus.s_arready = 0; bus.s_rvalid = 0; bus.s_rlast = 0; bus.s_awready = 0;
    bus.s_wready = 0; bus.s_bvalid = 0; bus.s_rresp = 0; bus.s_bresp = 0; bus.s_rdata = 0;
  endtask

  // Single read with every slave ready; mapped and unmapped take the same cycle count.
  task automatic rd_txn(input logic [31:0] addr, input logic [31:0] exp_data);
    bus.in_arvalid = 1; bus.in_araddr = addr; bus.s_arready = 3'b111;
    step();
    step();
    bus.in_arvalid = 0; bus.in_araddr = 0; bus.s_arready = 0;
    bus.s_rvalid = 3'b111; bus.s_rlast = 3'b111; bus.in_rready = 1;
    bus.s_rdata = {32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
    #1;
    check("rd_txn_data", 128'({bus.in_rvalid, bus.in_rdata}), 128'({1'b1, exp_data}));
    step();
    clear_inputs();
    step();
  endtask

  task automatic wr_txn(input logic [31:0] addr, input logic [1:0] exp_resp);
    bus.in_awvalid = 1; bus.in_wvalid = 1; bus.in_awaddr = addr; bus.in_wdata = 32'h0bad_cafe;
    bus.in_wstrb = 4'hf; bus.s_awready = 3'b111; bus.s_wready = 3'b111; bus.in_bready = 1;
    step();
    step();
    bus.in_awvalid = 0; bus.in_wvalid = 0; bus.s_awready = 0; bus.s_wready = 0;
    bus.s_bvalid = 3'b111; bus.s_bresp = 0;
    #1;
    check("wr_txn_resp", 128'({bus.in_bvalid, bus.in_bresp}), 128'({1'b1, exp_resp}));
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    // Pin the model's address map at its edges.
    check("dec_sram_lo",  128'(decode(32'h8000_0000)), 128'(0));
    check("dec_sram_hi",  128'(decode(32'h87ff_ffff)), 128'(0));
    check("dec_sram_out", 128'(decode(32'h8800_0000)), 128'(-1));
    check("dec_uart_hi",  128'(decode(32'ha000_03ff)), 128'(1));
    check("dec_uart_out", 128'(decode(32'ha000_0400)), 128'(-1));
    check("dec_clint_lo", 128'(decode(32'ha000_0048)), 128'(2));
    check("dec_clint_bl", 128'(decode(32'ha000_0047)), 128'(-1));
    check("dec_clint_out", 128'(decode(32'ha000_0058)), 128'(-1));

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 128'({bus.in_arready, bus.in_rvalid, bus.in_awready, bus.in_wready,
                              bus.in_bvalid, bus.s_arvalid, bus.s_awvalid, bus.s_wvalid}), 128'(0));
    rst = 1;
    step();

    // Single read from SRAM, data two cycles after the AR handshake.
    bus.in_arvalid = 1; bus.in_araddr = 32'h8000_0010; bus.s_arready = 3'b001;
    step();
    check("t1_route", 128'({bus.s_arvalid, bus.in_arready}), 128'({3'b001, 1'b1}));
    step();
    bus.in_arvalid = 0; bus.in_araddr = 0; bus.s_arready = 0;
    step();
    step();
    bus.s_rvalid = 3'b001; bus.s_rdata = 96'hDEADBEEF; bus.s_rlast = 3'b001; bus.in_rready = 1;
    #1;
    check("t1_rdata", 128'({bus.in_rvalid, bus.in_rresp, bus.in_rdata}),
          128'({1'b1, 2'b00, 32'hDEADBEEF}));
    step();
    clear_inputs();
    step();

    // Four-beat burst with a one-cycle stall on beat 2.
    bus.in_arvalid = 1; bus.in_araddr = 32'h8000_0100; bus.s_arready = 3'b001;
    step();
    step();
    bus.in_arvalid = 0; bus.in_araddr = 0; bus.s_arready = 0;
    begin
      int b;
      b = 0;
      for (int c = 0; c < 5; c++) begin
        bus.s_rvalid = 3'b001;
        bus.s_rdata = {64'h0, beats[b]};
        bus.s_rlast = (b == 3) ? 3'b001 : 3'b000;
        bus.in_rready = (c != 1);
        #1;
        check("t2_beat", 128'({bus.in_rvalid, bus.in_rlast, bus.in_rdata}),
              128'({1'b1, (b == 3), beats[b]}));
        step();
        if (c != 1) b++;
      end
    end
    clear_inputs();
    step();

    // UART write, awready one cycle before wready.
    bus.in_awvalid = 1; bus.in_wvalid = 1; bus.in_awaddr = 32'ha000_03f8;
    bus.in_wdata = 32'h41; bus.in_wstrb = 4'b0001; bus.in_bready = 1;
    step();
    check("t3_req", 128'({bus.s_awvalid, bus.s_wvalid, bus.s_wdata, bus.s_wstrb}),
          128'({3'b010, 3'b010, 32'h41, 4'b0001}));
    bus.s_awready = 3'b010;
    step();
    #1;
    check("t3_aw_masked", 128'({bus.s_awvalid, bus.in_awready, bus.s_wvalid}),
          128'({3'b000, 1'b0, 3'b010}));
    bus.s_wready = 3'b010;
    step();
    bus.in_awvalid = 0; bus.in_wvalid = 0; bus.s_awready = 0; bus.s_wready = 0;
    bus.s_bvalid = 3'b010;
    #1;
    check("t3_b", 128'({bus.in_bvalid, bus.in_bresp, bus.s_bready}), 128'({1'b1, 2'b00, 3'b010}));
    step();
    check("t3_single_b", 128'(bus.in_bvalid), 128'(0));
    clear_inputs();
    step();

    // Unmapped read and write together.
    bus.in_arvalid = 1; bus.in_araddr = 32'h0;
    bus.in_awvalid = 1; bus.in_wvalid = 1; bus.in_awaddr = 32'hffff_fff0; bus.in_wstrb = 4'hf;
    bus.s_arready = 3'b111; bus.s_awready = 3'b111; bus.s_wready = 3'b111;
    step();
    check("t4_ack", 128'({bus.in_arready, bus.in_awready, bus.in_wready, bus.s_arvalid,
                          bus.s_awvalid, bus.s_wvalid}), 128'({3'b111, 9'b0}));
    step();
    clear_inputs();
    #1;
    check("t4_resp", 128'({bus.in_rvalid, bus.in_rresp, bus.in_rdata, bus.in_rlast, bus.in_bvalid,
                           bus.in_bresp}), 128'({1'b1, 2'b11, 32'h0, 1'b1, 1'b1, 2'b11}));
    step();
    bus.in_rready = 1; bus.in_bready = 1;
    step();
    bus.in_rready = 0; bus.in_bready = 0;
    #1;
    check("t4_idle", 128'({bus.in_rvalid, bus.in_bvalid}), 128'(0));
    step();

    // Concurrent CLINT read and SRAM write.
    bus.in_arvalid = 1; bus.in_araddr = 32'ha000_0048; bus.s_arready = 3'b100;
    bus.in_awvalid = 1; bus.in_wvalid = 1; bus.in_awaddr = 32'h8000_0000;
    bus.in_wdata = 32'h1234_5678; bus.in_wstrb = 4'hf; bus.s_awready = 3'b001;
    bus.s_wready = 3'b001;
    step();
    check("t5_route", 128'({bus.s_arvalid, bus.s_awvalid, bus.s_wvalid, bus.in_arready,
                            bus.in_awready, bus.in_wready}),
          128'({3'b100, 3'b001, 3'b001, 3'b111}));
    step();
    clear_inputs();
    bus.s_rvalid = 3'b100; bus.s_rdata = {32'hCAFEF00D, 64'h0}; bus.s_rlast = 3'b100;
    bus.in_rready = 1; bus.s_bvalid = 3'b001; bus.in_bready = 1;
    #1;
    check("t5_resp", 128'({bus.in_rvalid, bus.in_rdata, bus.in_rlast, bus.s_rready, bus.in_bvalid,
                           bus.s_bready}),
          128'({1'b1, 32'hCAFEF00D, 1'b1, 3'b100, 1'b1, 3'b001}));
    step();
    clear_inputs();
    step();

    // Reset in the middle of a read data phase.
    bus.in_arvalid = 1; bus.in_araddr = 32'h8000_0020; bus.s_arready = 3'b001;
    step();
    step();
    clear_inputs();
    bus.s_rvalid = 3'b001; bus.s_rdata = 96'h77; bus.in_rready = 1;
    #1;
    check("t6_pre", 128'({bus.in_rvalid, bus.s_rready}), 128'({1'b1, 3'b001}));
    rst = 0;
    #1;
    check("t6_rst", 128'({bus.in_arready, bus.in_rvalid, bus.in_awready, bus.in_wready,
                          bus.in_bvalid, bus.s_arvalid, bus.s_rready, bus.s_awvalid,
                          bus.s_wvalid, bus.s_bready}), 128'(0));
    step();
    step();
    clear_inputs();
    rst = 1;
    step();
    rd_txn(32'h8000_0020, 32'h5000_0000);

    // Map boundaries through the DUT.
    rd_txn(32'h87ff_fffc, 32'h5000_0000);
    rd_txn(32'h8800_0000, 32'h0);
    rd_txn(32'ha000_03ff, 32'h5000_0001);
    rd_txn(32'ha000_0057, 32'h5000_0002);
    rd_txn(32'ha000_0058, 32'h0);
    wr_txn(32'ha000_03fc, 2'b00);
    wr_txn(32'ha000_0400, 2'b11);
    wr_txn(32'ha000_0050, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_xbar.md
Name: axi_xbar

Overview:
- 1-to-3 AXI4-lite address router between the memory-bus arbiter output and the SoC slaves: slave0 SRAM, slave1 UART, slave2 CLINT.
- Read and write channels are scheduled independently; each has one outstanding transaction.
- Unmapped addresses are completed locally with DECERR, so the pipeline never hangs.
- Burst reads pass through: rlast from the slave ends the read transaction.

Parameters:
- SRAM_BASE, 32'h8000_0000, slave0 base address
- SRAM_SIZE, 32'h0800_0000, slave0 byte span
- UART_BASE, 32'ha000_03f8, slave1 base address
- UART_SIZE, 32'h0000_0008, slave1 byte span
- CLINT_BASE, 32'ha000_0048, slave2 base address
- CLINT_SIZE, 32'h0000_0010, slave2 byte span

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_arvalid, in_rready  in  1  upstream read requests
- in_araddr  in  32  upstream read address
- in_arready, in_rvalid, in_rlast  out  1  upstream read responses
- in_rresp  out  2  upstream read response code
- in_rdata  out  32  upstream read data
- in_awvalid, in_wvalid, in_bready  in  1  upstream write requests
- in_awaddr, in_wdata  in  32  upstream write address and data
- in_wstrb  in  4  upstream write byte strobes
- in_awready, in_wready, in_bvalid  out  1  upstream write responses
- in_bresp  out  2  upstream write response code
- s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready  out  3  per-slave one-hot, bit i = slave i
- s_araddr, s_awaddr, s_wdata  out  32  broadcast to all slaves
- s_wstrb  out  4  broadcast to all slaves
- s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid  in  3  per slave
- s_rresp, s_bresp  in  6  per slave, {s2,s1,s0}
- s_rdata  in  96  per slave, {s2,s1,s0}

Behaviour:
- Decode: slave i hit iff BASE_i <= addr < BASE_i + SIZE_i. Compute in 33 bits so no wrap at 2^32. No hit means ERR target. Address ranges never overlap.
- Read FSM states: R_IDLE, R_ADDR, R_DATA, R_ERR. Latched 2-bit rtarget.
  - R_IDLE: if in_arvalid, decode in_araddr, latch rtarget, go to R_ADDR, or to R_ERR if unmapped. All upstream read outputs are 0 in this state.
  - R_ADDR: s_arvalid[t]=in_arvalid, s_araddr=in_araddr, in_arready=s_arready[t]. On the handshake go to R_DATA.
  - R_DATA: in_rvalid/rdata/rresp/rlast are muxed from slave t; s_rready[t]=in_rready. When rvalid & rready & rlast, go to R_IDLE.
  - R_ERR: first cycle asserts in_arready=1 (consumes the AR beat). Following cycles hold in_rvalid=1, rresp=2'b11, rdata=0, rlast=1 until in_rready, then go to R_IDLE.
- Write FSM states: W_IDLE, W_REQ, W_RESP, W_ERR. Latched wtarget, plus aw_done and w_done flags.
  - W_IDLE: wait for in_awvalid && in_wvalid, decode in_awaddr, clear both flags.
  - W_REQ: AW and W are forwarded to slave t independently. A channel's valid is masked once its done flag is set. Go to W_RESP when both flags are set, counting same-cycle handshakes.
  - W_RESP: B is muxed from slave t. On bvalid & bready go to W_IDLE.
  - W_ERR: in_awready=in_wready=1 for one cycle, then bvalid=1 with bresp=2'b11 until bready.
- Minimum latency is one decode cycle in IDLE before the slave sees valid. Back-to-back transactions therefore cost one idle cycle each.
- Read and write FSMs run concurrently, including to the same slave. Ordering between reads and writes is not enforced.
- All outputs are combinational from state, latched target and inputs. Non-selected slaves see valid/ready = 0. Broadcast buses are driven to 0 outside R_ADDR/W_REQ.
- Reset: async assert forces R_IDLE/W_IDLE and clears targets and flags. Every valid/ready output is 0 during reset. An in-flight transaction is abandoned; no response is generated.

Decomposition:
- Shared package holds: state encodings, target encodings (S_SRAM=0, S_UART=1, S_CLINT=2, S_ERR=3), and RESP_OKAY=2'b00, RESP_DECERR=2'b11.
- One sub-module, axi_addr_decode: purely combinational addr -> 2-bit target, parameterised by the map. It is instantiated twice, for AR and AW.

Test Plan:
- Read 0x8000_0010, SRAM returns rdata=0xDEADBEEF, rlast=1 after 2 cycles -> only s_arvalid[0] asserted; upstream sees 0xDEADBEEF with rresp=0; FSM back to R_IDLE the next cycle.
- 4-beat burst from SRAM with rlast on beat 4; in_rready is deasserted for 1 cycle on beat 2 -> all 4 beats delivered in order; state stays R_DATA until beat 4.
- Write 0xa000_03f8, wdata=0x41, wstrb=4'b0001; UART gives awready one cycle before wready -> s_awvalid[1] drops after its handshake; a single bvalid reaches upstream.
- Read 0x0000_0000 and write 0xffff_fff0 (unmapped) -> rresp=2'b11, rdata=0, rlast=1; bresp=2'b11; no s_* valid ever asserted.
- Concurrent read from CLINT 0xa000_0048 and write to SRAM 0x8000_0000 -> both complete independently with correct one-hot routing.
- rst pulled low mid-R_DATA -> all valid/ready outputs go to 0 immediately; after release, a fresh read to SRAM completes normally.
